multicycle_controller: RTL and testbench

Multi-cycle MIPS control unit: a state machine that sequences fetch, decode, execute, memory and writeback over several clocks on one shared memory port and one ALU. It waits on a memory ready handshake, with a programmable timeout. It adds `bne`, `andi`, `ori`, `slti` and `j`, flags illegal instructions, and counts retired instructions. It sits beside the multi-cycle datapath, which holds PC, IR, A/B, MDR and ALUOut.

---
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller.sv | 178 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control and status bundle between the multi-cycle controller and its datapath
interface multicycle_controller_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             zero;
   logic             mem_ready;
   logic             memread;
   logic             memwrite;
   logic             iord;
   logic             irwrite;
   logic             pcen;
   logic [1:0]       pcsrc;
   logic             alusrca;
   logic [1:0]       alusrcb;
   logic [2:0]       alucont;
   logic             zeroext;
   logic             regdst;
   logic             memtoreg;
   logic             regwrite;
   logic             illegal;
   logic             mem_err;
   logic [CNT_W-1:0] instret;

   modport master (
      input  op, funct, zero, mem_ready,
      output memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, alucont,
             zeroext, regdst, memtoreg, regwrite, illegal, mem_err, instret
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, alucont,
             zeroext, regdst, memtoreg, regwrite, illegal, mem_err, instret
   );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle MIPS control FSM with memory-ready watchdog and retired-instruction counter
module multicycle_controller #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input logic                     clk,
   input logic                     resetn,
   multicycle_controller_if.master bus
);
   localparam int cw = $clog2(TIMEOUT + 2);
   localparam logic [cw-1:0] wd_limit = cw'(TIMEOUT);

   localparam logic [5:0] op_rtype = 6'h00;
   localparam logic [5:0] op_j     = 6'h02;
   localparam logic [5:0] op_beq   = 6'h04;
   localparam logic [5:0] op_bne   = 6'h05;
   localparam logic [5:0] op_addi  = 6'h08;
   localparam logic [5:0] op_slti  = 6'h0A;
   localparam logic [5:0] op_andi  = 6'h0C;
   localparam logic [5:0] op_ori   = 6'h0D;
   localparam logic [5:0] op_lw    = 6'h23;
   localparam logic [5:0] op_sw    = 6'h2B;

   localparam logic [5:0] fn_add = 6'h20;
   localparam logic [5:0] fn_sub = 6'h22;
   localparam logic [5:0] fn_and = 6'h24;
   localparam logic [5:0] fn_or  = 6'h25;
   localparam logic [5:0] fn_slt = 6'h2A;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      RTYPEEX, ALUWB, BRANCH, IMMEX, IMMWB, JUMP
   } state_t;

   state_t           state, state_n;
   logic [cw-1:0]    wcnt;
   logic [CNT_W-1:0] count;
   logic             r_ok, is_mem, is_br, is_imm;
   logic             waiting, abort, retire;

   assign r_ok   = bus.op == op_rtype &&
                   (bus.funct == fn_add || bus.funct == fn_sub || bus.funct == fn_and ||
                    bus.funct == fn_or  || bus.funct == fn_slt);
   assign is_mem = bus.op == op_lw || bus.op == op_sw;
   assign is_br  = bus.op == op_beq || bus.op == op_bne;
   assign is_imm = bus.op == op_addi || bus.op == op_andi || bus.op == op_ori || bus.op == op_slti;

   // Only the three memory-facing states can stall on mem_ready; a ready in the
   // same cycle as the limit wins, so the abort requires ready to be low.
   assign waiting = state == FETCH || state == MEMRD || state == MEMWR;
   assign abort   = TIMEOUT != 0 && waiting && !bus.mem_ready && wcnt == wd_limit;
   assign retire  = state == MEMWB || state == ALUWB || state == BRANCH ||
                    state == IMMWB || state == JUMP  || (state == MEMWR && bus.mem_ready);

   assign bus.instret = count;

   // State, watchdog counter and retired-instruction counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         wcnt  <= '0;
         count <= '0;
      end else begin
         state <= state_n;
         wcnt  <= (state_n != state || bus.mem_ready || !waiting) ? '0 : wcnt + 1'b1;
         if (retire) count <= count + 1'b1;
      end
   end

   // Next state and state-decoded control outputs, with the watchdog abort overriding last
   always_comb begin
      state_n      = state;
      bus.memread  = 1'b0;
      bus.memwrite = 1'b0;
      bus.iord     = 1'b0;
      bus.irwrite  = 1'b0;
      bus.pcen     = 1'b0;
      bus.pcsrc    = 2'b00;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = 2'b00;
      bus.alucont  = 3'b000;
      bus.zeroext  = 1'b0;
      bus.regdst   = 1'b0;
      bus.memtoreg = 1'b0;
      bus.regwrite = 1'b0;
      bus.illegal  = 1'b0;
      bus.mem_err  = 1'b0;
      case (state)
         IDLE: state_n = FETCH;
         FETCH: begin
            bus.memread = 1'b1;
            bus.alusrcb = 2'b01;
            bus.alucont = 3'b010;
            bus.irwrite = bus.mem_ready;
            bus.pcen    = bus.mem_ready;
            state_n     = bus.mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            bus.alusrcb = 2'b11;
            bus.alucont = 3'b010;
            bus.illegal = !(is_mem || r_ok || is_br || is_imm || bus.op == op_j);
            state_n     = is_mem ? MEMADR :
                          r_ok   ? RTYPEEX :
                          is_br  ? BRANCH :
                          is_imm ? IMMEX :
                          bus.op == op_j ? JUMP : FETCH;
         end
         MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            bus.alucont = 3'b010;
            state_n     = bus.op == op_lw ? MEMRD : MEMWR;
         end
         MEMRD: begin
            bus.memread = 1'b1;
            bus.iord    = 1'b1;
            state_n     = bus.mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            bus.memtoreg = 1'b1;
            bus.regwrite = 1'b1;
            state_n      = FETCH;
         end
         MEMWR: begin
            bus.memwrite = 1'b1;
            bus.iord     = 1'b1;
            state_n      = bus.mem_ready ? FETCH : MEMWR;
         end
         RTYPEEX: begin
            bus.alusrca = 1'b1;
            bus.alucont = bus.funct == fn_sub ? 3'b110 :
                          bus.funct == fn_and ? 3'b000 :
                          bus.funct == fn_or  ? 3'b001 :
                          bus.funct == fn_slt ? 3'b111 : 3'b010;
            state_n     = ALUWB;
         end
         ALUWB: begin
            bus.regdst   = 1'b1;
            bus.regwrite = 1'b1;
            state_n      = FETCH;
         end
         BRANCH: begin
            bus.alusrca = 1'b1;
            bus.alucont = 3'b110;
            bus.pcsrc   = 2'b01;
            bus.pcen    = (bus.op == op_beq && bus.zero) || (bus.op == op_bne && !bus.zero);
            state_n     = FETCH;
         end
         IMMEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            bus.alucont = bus.op == op_andi ? 3'b000 :
                          bus.op == op_ori  ? 3'b001 :
                          bus.op == op_slti ? 3'b111 : 3'b010;
            bus.zeroext = bus.op == op_andi || bus.op == op_ori;
            state_n     = IMMWB;
         end
         IMMWB: begin
            bus.regwrite = 1'b1;
            state_n      = FETCH;
         end
         JUMP: begin
            bus.pcsrc = 2'b10;
            bus.pcen  = 1'b1;
            state_n   = FETCH;
         end
         default: state_n = IDLE;
      endcase
      if (abort) begin
         bus.memread  = 1'b0;
         bus.memwrite = 1'b0;
         bus.irwrite  = 1'b0;
         bus.pcen     = 1'b0;
         bus.mem_err  = 1'b1;
         state_n      = IDLE;
      end
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized instruction streams checked against an ISA-level timing model
module tb_multicycle_controller;
   logic clk    = 1'b0;
   logic resetn = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   exp_instret = 0;
   int   obs  [13];
   int   expv [13];
   string fname [13] = '{"cycles", "illegal", "regwrite", "memtoreg", "regdst", "exec_alucont",
                         "exec_alusrcb", "zeroext", "late_pcen", "pcsrc", "data_req", "memwrite", "instret"};

   multicycle_controller_if #(.CNT_W(32)) bus  ();
   multicycle_controller_if #(.CNT_W(32)) bus4 ();
   multicycle_controller_if #(.CNT_W(32)) bus0 ();

   multicycle_controller #(.TIMEOUT(16), .CNT_W(32)) dut  (.clk(clk), .resetn(resetn), .bus(bus));
   multicycle_controller #(.TIMEOUT(4),  .CNT_W(32)) dut4 (.clk(clk), .resetn(resetn), .bus(bus4));
   multicycle_controller #(.TIMEOUT(0),  .CNT_W(32)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));

   logic [18:0] outs, outs4;
   assign outs  = {bus.memread, bus.memwrite, bus.iord, bus.irwrite, bus.pcen, bus.pcsrc, bus.alusrca,
                   bus.alusrcb, bus.alucont, bus.zeroext, bus.regdst, bus.memtoreg, bus.regwrite,
                   bus.illegal, bus.mem_err};
   assign outs4 = {bus4.memread, bus4.memwrite, bus4.iord, bus4.irwrite, bus4.pcen, bus4.pcsrc, bus4.alusrca,
                   bus4.alusrcb, bus4.alucont, bus4.zeroext, bus4.regdst, bus4.memtoreg, bus4.regwrite,
                   bus4.illegal, bus4.mem_err};

   always #5 clk = ~clk;

   // Expected per-instruction observables from the ISA rules: CPI, writes, exec ALU setup, PC update.
   task automatic model(input logic [5:0] o, input logic [5:0] f, input logic z, input int wf, input int wm);
      bit r_ok = (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A);
      expv = '{default: 0};
      expv[5] = -1;
      expv[6] = -1;
      expv[0] = wf;
      if (o == 6'h23 || o == 6'h2B) begin
         expv[0] += (o == 6'h23 ? 5 : 4) + wm;
         expv[2] = (o == 6'h23) ? 1 : 0;
         expv[3] = expv[2];
         expv[5] = 2;
         expv[6] = 2;
         expv[10] = wm + 1;
         expv[11] = (o == 6'h2B) ? wm + 1 : 0;
      end else if (o == 6'h00 && r_ok) begin
         expv[0] += 4;
         expv[2] = 1;
         expv[4] = 1;
         expv[5] = f == 6'h22 ? 6 : f == 6'h24 ? 0 : f == 6'h25 ? 1 : f == 6'h2A ? 7 : 2;
         expv[6] = 0;
      end else if (o == 6'h04 || o == 6'h05) begin
         expv[0] += 3;
         expv[5] = 6;
         expv[6] = 0;
         expv[8] = ((o == 6'h04) ? z : !z) ? 1 : 0;
         expv[9] = 1;
      end else if (o == 6'h08 || o == 6'h0C || o == 6'h0D || o == 6'h0A) begin
         expv[0] += 4;
         expv[2] = 1;
         expv[5] = o == 6'h0C ? 0 : o == 6'h0D ? 1 : o == 6'h0A ? 7 : 2;
         expv[6] = 2;
         expv[7] = (o == 6'h0C || o == 6'h0D) ? 1 : 0;
      end else if (o == 6'h02) begin
         expv[0] += 3;
         expv[8] = 1;
         expv[9] = 2;
      end else begin
         expv[0] += 2;
         expv[1] = 1;
      end
      if (expv[1] == 0) exp_instret++;
      expv[12] = exp_instret;
   endtask

   // Drives one instruction on the main DUT from its FETCH cycle until the next FETCH, recording observables.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int wf, input int wm);
      int fw = wf;
      int mw = wm;
      bit fetch_done = 0;
      bit done = 0;
      obs = '{default: 0};
      obs[5] = -1;
      obs[6] = -1;
      bus.op = o;
      bus.funct = f;
      bus.zero = z;
      for (int g = 0; g < 64; g++) begin
         if (bus.memread && !bus.iord) begin
            bus.mem_ready = (fw == 0);
            if (fw == 0) fetch_done = 1;
            else fw--;
         end else if ((bus.memread && bus.iord) || bus.memwrite) begin
            bus.mem_ready = (mw == 0);
            if (mw != 0) mw--;
            obs[10]++;
            if (bus.memwrite) obs[11]++;
         end else bus.mem_ready = 1'($urandom_range(0, 1));
         #1;
         obs[1] += int'(bus.illegal);
         obs[2] += int'(bus.regwrite);
         obs[3] += int'(bus.memtoreg);
         if (bus.regwrite) obs[4] = int'(bus.regdst);
         if (bus.alusrca) begin
            obs[5] = int'(bus.alucont);
            obs[6] = int'(bus.alusrcb);
         end
         obs[7] |= int'(bus.zeroext);
         if (bus.pcen && !(bus.memread && !bus.iord)) obs[8] = 1;
         if (bus.pcsrc != 2'b00) obs[9] = int'(bus.pcsrc);
         @(negedge clk);
         obs[0]++;
         if (bus.memread && !bus.iord && fetch_done) begin
            done = 1;
            break;
         end
      end
      obs[12] = int'(bus.instret);
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL run_instr_timeout op=%h: got no return to FETCH within 64 cycles, required return", o);
      end
   endtask

   task automatic test_reset();
      #1 resetn = 1'b0;
      @(negedge clk); #1;
      checks++; if (outs !== 19'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
      checks++; if (bus.instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", bus.instret); end
      resetn = 1'b1;
      @(negedge clk); #1;
      checks++; if ({bus.memread, bus.iord} !== 2'b10) begin errors++; $display("FAIL reset_release_fetch: got %b expected 10", {bus.memread, bus.iord}); end
      run_instr(6'h00, 6'h20, 1'b0, 0, 0);
      exp_instret++;
      bus.op = 6'h23;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      @(negedge clk); #1;
      checks++; if ({bus.memread, bus.iord, bus.instret} !== {2'b11, 32'd1}) begin errors++; $display("FAIL memrd_before_reset: got %b/%0d expected 11/1", {bus.memread, bus.iord}, bus.instret); end
      #1 resetn = 1'b0;
      #1;
      checks++; if (outs !== 19'd0) begin errors++; $display("FAIL async_reset_outputs: got %h expected 0", outs); end
      checks++; if (bus.instret !== 32'd0) begin errors++; $display("FAIL async_reset_instret: got %0d expected 0", bus.instret); end
      exp_instret = 0;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      checks++; if (outs !== 19'd0) begin errors++; $display("FAIL idle_after_release: got %h expected 0", outs); end
      @(negedge clk);
      checks++; if ({bus.memread, bus.iord} !== 2'b10) begin errors++; $display("FAIL fetch_after_idle: got %b expected 10", {bus.memread, bus.iord}); end
   endtask

   task automatic test_rtype();
      run_instr(6'h00, 6'h20, 1'b0, 0, 0);
      exp_instret++;
      checks++; if (obs[0] !== 4) begin errors++; $display("FAIL rtype_cycles: got %0d expected 4", obs[0]); end
      checks++; if (obs[5] !== 2) begin errors++; $display("FAIL rtype_alucont: got %0d expected 2", obs[5]); end
      checks++; if (obs[2] !== 1 || obs[4] !== 1) begin errors++; $display("FAIL rtype_writeback: got regwrite=%0d regdst=%0d expected 1/1", obs[2], obs[4]); end
      checks++; if (obs[12] !== exp_instret) begin errors++; $display("FAIL rtype_instret: got %0d expected %0d", obs[12], exp_instret); end
   endtask

   task automatic test_lw_wait();
      run_instr(6'h23, 6'h00, 1'b0, 0, 3);
      exp_instret++;
      checks++; if (obs[0] !== 8) begin errors++; $display("FAIL lw_wait_cycles: got %0d expected 8", obs[0]); end
      checks++; if (obs[10] !== 4) begin errors++; $display("FAIL lw_wait_memrd_cycles: got %0d expected 4", obs[10]); end
      checks++; if (obs[3] !== 1) begin errors++; $display("FAIL lw_wait_memtoreg: got %0d expected 1", obs[3]); end
      checks++; if (obs[12] !== exp_instret) begin errors++; $display("FAIL lw_wait_instret: got %0d expected %0d", obs[12], exp_instret); end
   endtask

   task automatic test_branches();
      run_instr(6'h04, 6'h00, 1'b1, 0, 0);
      exp_instret++;
      checks++; if (obs[8] !== 1 || obs[9] !== 1) begin errors++; $display("FAIL beq_taken: got pcen=%0d pcsrc=%0d expected 1/1", obs[8], obs[9]); end
      checks++; if (obs[0] !== 3 || obs[12] !== exp_instret) begin errors++; $display("FAIL beq_timing: got cycles=%0d instret=%0d expected 3/%0d", obs[0], obs[12], exp_instret); end
      run_instr(6'h05, 6'h00, 1'b1, 0, 0);
      exp_instret++;
      checks++; if (obs[8] !== 0) begin errors++; $display("FAIL bne_not_taken: got pcen=%0d expected 0", obs[8]); end
      checks++; if (obs[0] !== 3 || obs[12] !== exp_instret) begin errors++; $display("FAIL bne_timing: got cycles=%0d instret=%0d expected 3/%0d", obs[0], obs[12], exp_instret); end
   endtask

   task automatic test_illegal();
      run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
      checks++; if (obs[1] !== 1 || obs[0] !== 2) begin errors++; $display("FAIL illegal_op: got pulses=%0d cycles=%0d expected 1/2", obs[1], obs[0]); end
      checks++; if (obs[12] !== exp_instret) begin errors++; $display("FAIL illegal_op_instret: got %0d expected %0d", obs[12], exp_instret); end
      run_instr(6'h00, 6'h08, 1'b0, 0, 0);
      checks++; if (obs[1] !== 1 || obs[0] !== 2) begin errors++; $display("FAIL illegal_funct: got pulses=%0d cycles=%0d expected 1/2", obs[1], obs[0]); end
      checks++; if (obs[12] !== exp_instret) begin errors++; $display("FAIL illegal_funct_instret: got %0d expected %0d", obs[12], exp_instret); end
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [12] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h3F};
      logic [5:0] fns [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
      logic [5:0] o, f;
      logic z;
      int wf, wm;
      for (int n = 0; n < 80; n++) begin
         o  = ops[$urandom_range(0, 11)];
         if ($urandom_range(0, 9) == 0) o = 6'($urandom);
         f  = fns[$urandom_range(0, 5)];
         z  = 1'($urandom);
         wf = $urandom_range(0, 3);
         wm = $urandom_range(0, 3);
         model(o, f, z, wf, wm);
         run_instr(o, f, z, wf, wm);
         for (int i = 0; i < 13; i++) begin
            checks++;
            if (obs[i] !== expv[i]) begin
               errors++;
               $display("FAIL random[%0d] op=%h funct=%h zero=%b wf=%0d wm=%0d %s: got %0d expected %0d",
                        n, o, f, z, wf, wm, fname[i], obs[i], expv[i]);
            end
         end
      end
   endtask

   task automatic test_watchdog();
      int e0 = 0;
      int w0 = 0;
      bus4.op = 6'h2B;
      bus0.op = 6'h2B;
      bus4.mem_ready = 1'b1;
      bus0.mem_ready = 1'b1;
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      bus4.mem_ready = 1'b0;
      bus0.mem_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk); #1;
         checks++;
         if ({bus4.memwrite, bus4.mem_err} !== (k == 5 ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL watchdog_memwr_cycle%0d: got memwrite/mem_err=%b expected %b", k, {bus4.memwrite, bus4.mem_err}, (k == 5 ? 2'b01 : 2'b10));
         end
      end
      @(negedge clk); #1;
      checks++; if (outs4 !== 19'd0) begin errors++; $display("FAIL watchdog_idle: got %h expected 0", outs4); end
      checks++; if (bus4.instret !== 32'd0) begin errors++; $display("FAIL watchdog_instret: got %0d expected 0", bus4.instret); end
      @(negedge clk); #1;
      checks++; if ({bus4.memread, bus4.iord, bus4.mem_err} !== 3'b100) begin errors++; $display("FAIL watchdog_refetch: got %b expected 100", {bus4.memread, bus4.iord, bus4.mem_err}); end
      bus4.op = 6'h23;
      for (int c = 2; c <= 4; c++) @(negedge clk);
      @(negedge clk);
      bus4.mem_ready = 1'b1;
      #1;
      checks++; if ({bus4.irwrite, bus4.pcen, bus4.mem_err} !== 3'b110) begin errors++; $display("FAIL ready_at_limit: got irwrite/pcen/mem_err=%b expected 110", {bus4.irwrite, bus4.pcen, bus4.mem_err}); end
      @(negedge clk); #1;
      checks++; if ({bus4.alusrcb, bus4.memread, bus4.mem_err} !== 4'b1100) begin errors++; $display("FAIL ready_at_limit_decode: got %b expected 1100", {bus4.alusrcb, bus4.memread, bus4.mem_err}); end
      for (int c = 0; c < 30; c++) begin
         @(negedge clk); #1;
         if (bus0.mem_err) e0++;
         if (!bus0.memwrite) w0++;
      end
      checks++; if (e0 !== 0) begin errors++; $display("FAIL timeout0_mem_err: got %0d pulses expected 0", e0); end
      checks++; if (w0 !== 0) begin errors++; $display("FAIL timeout0_memwrite_held: got %0d dropped cycles expected 0", w0); end
   endtask

   initial begin
      {bus.op, bus.funct, bus.zero, bus.mem_ready}     = '0;
      {bus4.op, bus4.funct, bus4.zero, bus4.mem_ready} = '0;
      {bus0.op, bus0.funct, bus0.zero, bus0.mem_ready} = '0;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_branches();
      test_illegal();
      test_back_to_back();
      test_watchdog();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1, "simulation time limit reached");
   end
endmodule
